// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - parametrised multi-CS SPI master, CPOL/CPHA per transfer; option macro SPI_LSB_FIRST_EN
module spi_master_multi #(
    parameter int DATA_W  = 16,
    parameter int CS_NUM  = 4,
    parameter int CLK_DIV = 4,
    localparam int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              spi_en,
    input  logic [1:0]        spi_mode,
    input  logic [CS_W-1:0]   spi_cs_sel,
    input  logic [DATA_W-1:0] spi_sdata,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_done,
    output logic              spi_busy,
    output logic [CS_NUM-1:0] spi_csn,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int HC_W = $clog2(CLK_DIV);
    localparam int EC_W = $clog2(2*DATA_W+1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV-1);
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(2*DATA_W-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HC_W-1:0]   hcnt;
    logic [EC_W-1:0]   ecnt;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] tx_next;
    logic              hc_last;
    logic              leading;

    // Out-of-range selects decode to no active line at all.
    function automatic logic [CS_NUM-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [CS_NUM-1:0] csn;
        csn = '1;
        for (int i = 0; i < CS_NUM; i++) begin
            if (int'(sel) == i) csn[i] = 1'b0;
        end
        return csn;
    endfunction

    function automatic logic first_bit(input logic [DATA_W-1:0] d);
`ifdef SPI_LSB_FIRST_EN
        return d[0];
`else
        return d[DATA_W-1];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] d);
`ifdef SPI_LSB_FIRST_EN
        return {1'b0, d[DATA_W-1:1]};
`else
        return {d[DATA_W-2:0], 1'b0};
`endif
    endfunction

    function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] d, input logic b);
`ifdef SPI_LSB_FIRST_EN
        return {b, d[DATA_W-1:1]};
`else
        return {d[DATA_W-2:0], b};
`endif
    endfunction

    assign hc_last = (hcnt == HC_LAST);
    // ecnt counts edges already issued, so the edge about to be issued is leading when ecnt is even.
    assign leading = ~ecnt[0];
    assign tx_next = tx_advance(tx_sh);

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state logic: each phase ends on the last cycle of its half-period.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (spi_en) state_next = S_SETUP;
            S_SETUP: if (hc_last) state_next = S_XFER;
            S_XFER:  if (hc_last && ecnt == EC_LAST) state_next = S_HOLD;
            S_HOLD:  if (hc_last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered pin outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hcnt      <= '0;
            ecnt      <= '0;
            mode_q    <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            spi_rdata <= '0;
            spi_done  <= 1'b0;
            spi_busy  <= 1'b0;
            spi_csn   <= '1;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            spi_done <= 1'b0;
            if (state == S_SETUP || state == S_XFER || state == S_HOLD)
                hcnt <= hc_last ? '0 : hcnt + HC_W'(1);
            else
                hcnt <= '0;

            case (state)
                S_IDLE: begin
                    ecnt     <= '0;
                    spi_clk  <= spi_mode[1];
                    spi_mosi <= 1'b0;
                    spi_csn  <= '1;
                    spi_busy <= spi_en;
                    if (spi_en) begin
                        mode_q   <= spi_mode;
                        tx_sh    <= spi_sdata;
                        rx_sh    <= '0;
                        spi_csn  <= cs_decode(spi_cs_sel);
                        spi_mosi <= first_bit(spi_sdata);
                    end
                end
                S_XFER: begin
                    if (hc_last) begin
                        ecnt    <= ecnt + EC_W'(1);
                        spi_clk <= ~spi_clk;
                        // CPHA=0 samples on leading edges, CPHA=1 on trailing edges;
                        // the other edge shifts, except the very first and very last edge.
                        if (leading ^ mode_q[0]) begin
                            rx_sh <= rx_insert(rx_sh, spi_miso);
                        end else if (ecnt != '0 && ecnt != EC_LAST) begin
                            tx_sh    <= tx_next;
                            spi_mosi <= first_bit(tx_next);
                        end
                    end
                end
                S_HOLD: begin
                    if (hc_last) begin
                        spi_csn   <= '1;
                        spi_mosi  <= 1'b0;
                        spi_done  <= 1'b1;
                        spi_rdata <= rx_sh;
                    end
                end
                S_DONE: begin
                    spi_busy <= 1'b0;
                    spi_clk  <= mode_q[1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - self-checking bench for spi_master_multi with a cycle-level behavioural model
`timescale 1ns/1ps
module tb_spi_master_multi;

    localparam int DW      = 16;
    localparam int CSN     = 6;
    localparam int DIV     = 4;
    localparam int CSW     = 3;
    localparam int T_XFER0 = DIV + 1;
    localparam int T_HOLD0 = DIV + 2*DW*DIV + 1;
    localparam int T_DONE  = (2*DW + 2)*DIV + 1;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic           spi_en = 1'b0;
    logic [1:0]     spi_mode = 2'b00;
    logic [CSW-1:0] spi_cs_sel = '0;
    logic [DW-1:0]  spi_sdata = '0;
    logic [DW-1:0]  spi_rdata;
    logic           spi_done;
    logic           spi_busy;
    logic [CSN-1:0] spi_csn;
    logic           spi_clk;
    logic           spi_mosi;
    logic           spi_miso;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int sclk_edges = 0;

    logic          use_loop = 1'b1;
    logic [DW-1:0] slave_word = '0;
    logic          slave_bit = 1'b0;

    bit             m_active = 1'b0;
    int             m_c = 0;
    logic [1:0]     m_mode = 2'b00;
    logic [CSW-1:0] m_sel = '0;
    logic [DW-1:0]  m_data = '0;
    logic [DW-1:0]  m_rx = '0;
    logic [DW-1:0]  m_sw = '0;
    logic           exp_idle_clk = 1'b0;
    logic [DW-1:0]  exp_rdata = '0;

    spi_master_multi #(.DATA_W(DW), .CS_NUM(CSN), .CLK_DIV(DIV)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .spi_en     (spi_en),
        .spi_mode   (spi_mode),
        .spi_cs_sel (spi_cs_sel),
        .spi_sdata  (spi_sdata),
        .spi_rdata  (spi_rdata),
        .spi_done   (spi_done),
        .spi_busy   (spi_busy),
        .spi_csn    (spi_csn),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    assign spi_miso = use_loop ? spi_mosi : slave_bit;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // i-th bit on the wire for word w
    function automatic logic bit_at(input logic [DW-1:0] w, input int i);
`ifdef SPI_LSB_FIRST_EN
        return w[i];
`else
        return w[DW-1-i];
`endif
    endfunction

    // SCLK edges already produced when cycle c (1 = first cycle after accept) begins
    function automatic int toggles(input int c);
        if (c <= DIV) return 0;
        if (c >= T_HOLD0) return 2*DW;
        return (c - T_XFER0) / DIV;
    endfunction

    // index of the wire bit currently presented after n edges
    function automatic int bit_index(input logic cpha, input int n);
        int idx;
        if (cpha) idx = (n == 0) ? 0 : (n - 1) / 2;
        else      idx = n / 2;
        if (idx > DW-1) idx = DW-1;
        return idx;
    endfunction

    // Behavioural model advanced at each clock edge, compared mid-cycle.
    initial begin : model
        logic           e_busy, e_done, e_clk, e_mosi;
        logic [CSN-1:0] e_csn;
        int             n;
        forever begin
            @(posedge sys_clk);
            if (sys_rst) begin
                m_active = 1'b0; exp_idle_clk = 1'b0; exp_rdata = '0;
            end else if (m_active) begin
                m_c++;
                if (m_c == T_DONE) exp_rdata = m_rx;
                if (m_c == T_DONE + 1) begin
                    m_active = 1'b0;
                    exp_idle_clk = m_mode[1];
                end
            end else if (spi_en) begin
                m_active = 1'b1; m_c = 1;
                m_mode = spi_mode; m_sel = spi_cs_sel; m_data = spi_sdata; m_sw = slave_word;
                m_rx = use_loop ? spi_sdata : slave_word;
            end else begin
                exp_idle_clk = spi_mode[1];
            end

            @(negedge sys_clk);
            if (sys_rst) begin
                m_active = 1'b0; exp_idle_clk = 1'b0; exp_rdata = '0;
            end
            if (m_active) begin
                n      = toggles(m_c);
                e_busy = 1'b1;
                e_done = (m_c == T_DONE);
                e_csn  = (m_c < T_DONE && int'(m_sel) < CSN) ? ~(CSN'(1) << m_sel) : '1;
                e_clk  = m_mode[1] ^ n[0];
                e_mosi = (m_c == T_DONE) ? 1'b0 : bit_at(m_data, bit_index(m_mode[0], n));
            end else begin
                e_busy = 1'b0; e_done = 1'b0; e_csn = '1; e_clk = exp_idle_clk; e_mosi = 1'b0;
            end
            chk("busy", spi_busy, e_busy);
            chk("done", spi_done, e_done);
            chk("csn", spi_csn, e_csn);
            chk("sclk", spi_clk, e_clk);
            chk("mosi", spi_mosi, e_mosi);
            chk("rdata", spi_rdata, exp_rdata);
        end
    end

    // Slave device: presents bits of the latched slave word, shifting on the non-sampling SCLK edge.
    initial begin : slave
        logic prev_clk;
        logic prev_busy;
        prev_clk = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (spi_busy !== 1'b1 || !prev_busy) begin
                sclk_edges = 0;
                prev_clk = spi_clk;
            end else if (spi_clk !== prev_clk) begin
                sclk_edges++;
                prev_clk = spi_clk;
            end
            prev_busy = (spi_busy === 1'b1);
            slave_bit = bit_at(m_sw, bit_index(m_mode[0], sclk_edges));
        end
    end

    initial begin : done_counter
        forever begin
            @(negedge sys_clk);
            if (spi_done === 1'b1) done_cnt++;
        end
    end

    int t0;

    task automatic start(input logic [1:0] mode, input logic [CSW-1:0] sel, input logic [DW-1:0] data,
                         input logic loop, input logic [DW-1:0] sw);
        @(posedge sys_clk); #1;
        spi_mode = mode; spi_cs_sel = sel; spi_sdata = data;
        use_loop = loop; slave_word = sw; spi_en = 1'b1;
        t0 = cyc;
        @(posedge sys_clk); #1;
        spi_en = 1'b0;
    endtask

    task automatic wait_done(input bit noise, output int t);
        t = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (spi_done === 1'b1) begin
                t = cyc;
                break;
            end
            if (noise && m_active && m_c < T_DONE - 8) begin
                spi_mode = 2'($urandom); spi_sdata = DW'($urandom);
                spi_cs_sel = CSW'($urandom); spi_en = 1'($urandom);
            end else if (noise) begin
                spi_en = 1'b0;
            end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL done_timeout: no spi_done within 400 cycles (cycle %0d)", cyc);
        end
    endtask

    initial begin : stim
        int td, td2, d0;
        logic first_exp;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_csn", spi_csn, 6'h3F);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_busy", spi_busy, 0);
        chk("rst_rdata", spi_rdata, 0);
        sys_rst = 1'b0;
        repeat (2) @(posedge sys_clk);

        // mode 0 loopback
        start(2'b00, 3'd0, 16'hA55A, 1'b1, 16'h0000);
        chk("t1_csn", spi_csn, 6'b111110);
        chk("t1_busy", spi_busy, 1);
        wait_done(1'b0, td);
        chk("done_latency", td - t0, 137);
        chk("loop_rdata", spi_rdata, 16'hA55A);
        chk("sclk_edges", sclk_edges, 32);

        // modes 1..3 against the slave model
        for (int m = 1; m < 4; m++) begin
            start(2'(m), 3'd2, 16'h1111, 1'b0, 16'h3C96);
            chk("cs2_csn", spi_csn, 6'b111011);
            wait_done(1'b0, td);
            chk("mode_rdata", spi_rdata, 16'h3C96);
            @(posedge sys_clk);
            @(negedge sys_clk);
            chk("idle_sclk", spi_clk, 32'(m >> 1));
        end

        // chip-select decode, including out-of-range
        start(2'b00, 3'd5, 16'h0F0F, 1'b0, 16'h1234);
        chk("cs5_csn", spi_csn, 6'b011111);
        wait_done(1'b0, td);
        chk("cs5_rdata", spi_rdata, 16'h1234);
        start(2'b11, 3'd7, 16'hF00F, 1'b0, 16'hBEEF);
        chk("cs7_csn", spi_csn, 6'h3F);
        chk("cs7_busy", spi_busy, 1);
        wait_done(1'b0, td);
        chk("cs7_rdata", spi_rdata, 16'hBEEF);

        // spi_en pulse mid-transfer is ignored
        d0 = done_cnt;
        start(2'b01, 3'd1, 16'h6789, 1'b1, 16'h0000);
        repeat (40) @(posedge sys_clk);
        #1 spi_en = 1'b1;
        @(posedge sys_clk);
        #1 spi_en = 1'b0;
        wait_done(1'b0, td);
        repeat (10) @(posedge sys_clk);
        chk("single_done", done_cnt - d0, 1);

        // held spi_en: back-to-back transfers
`ifdef SPI_LSB_FIRST_EN
        first_exp = 1'b1;
`else
        first_exp = 1'b0;
`endif
        @(posedge sys_clk); #1;
        use_loop = 1'b1; spi_mode = 2'b00; spi_cs_sel = 3'd3; spi_sdata = 16'h0001; spi_en = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("first_mosi", spi_mosi, 32'(first_exp));
        wait_done(1'b0, td);
        spi_sdata = 16'h8000;
        chk("b2b_rdata0", spi_rdata, 16'h0001);
        wait_done(1'b0, td2);
        spi_en = 1'b0;
        chk("b2b_spacing", td2 - td, 138);
        chk("b2b_rdata1", spi_rdata, 16'h8000);

        // asynchronous reset at XFER edge 10
        d0 = done_cnt;
        start(2'b10, 3'd4, 16'h5AA5, 1'b1, 16'h0000);
        for (int i = 0; i < 200 && sclk_edges < 10; i++) @(negedge sys_clk);
        chk("edge10_reached", sclk_edges, 10);
        #1 sys_rst = 1'b1;
        #1;
        chk("arst_csn", spi_csn, 6'h3F);
        chk("arst_sclk", spi_clk, 0);
        chk("arst_busy", spi_busy, 0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        chk("arst_no_done", done_cnt - d0, 0);
        start(2'b01, 3'd4, 16'hC3A5, 1'b0, 16'h7E81);
        wait_done(1'b0, td);
        chk("post_rst_rdata", spi_rdata, 16'h7E81);

        // randomized transfers with in-flight input noise
        for (int n = 0; n < 14; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge sys_clk);
            start(2'($urandom), CSW'($urandom), DW'($urandom), 1'($urandom), DW'($urandom));
            wait_done(1'b1, td);
            chk("rand_latency", td - t0, T_DONE);
        end

        repeat (5) @(posedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
